ifu_prefetch_queue: RTL and testbench
=====================================

Name: ifu_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction fetch stage. It keeps a sequential prefetch stream running ahead of decode and buffers fetched {pc, instruction} pairs in a FQ_DEPTH-entry FIFO. It supports redirects at any time, including with a request in flight. It sits between the I-cache request/response port and the IDU valid/ready input.

Parameters:
XLEN, 32, width of PC and instruction.
RESET_PC, 32'h3000_0000, first fetch address after reset.
FQ_DEPTH, 4, fetch-queue entries; power of two, at least 2.

Ports:
clock  input  1  single clock, all state on rising edge
rst_n_sync  input  1  synchronous active-low reset
i_pc_update  input  1  redirect strobe from EXU/WBU
i_pc_next  input  XLEN  redirect target; bits [1:0] ignored (treated as 0)
o_post_valid  output  1  head entry valid to IDU
i_post_ready  input  1  IDU accepts head entry
o_ins  output  XLEN  head instruction
o_pc_next  output  XLEN  head PC
req  output  1  one-cycle I-cache request pulse
req_addr  output  XLEN  request address, meaningful when req=1
hit  input  1  cache hit flag, qualified by cache_valid
icache_ins  input  XLEN  response data, qualified by cache_valid
cache_valid  input  1  one-cycle response strobe
o_fq_count  output  $clog2(FQ_DEPTH)+1  current queue occupancy
o_hit_cnt  output  32  count of responses that were accepted and had hit=1

Behaviour:
- Reset (rst_n_sync=0 at a clock edge):
  - req=0, req_addr=0, o_post_valid=0, o_fq_count=0, o_hit_cnt=0, queue empty.
  - fetch_pc=RESET_PC, outstanding=0, drop=0.
- Request FSM, states IDLE and WAIT:
  - IDLE to WAIT: issue when no request is outstanding and o_fq_count + (a pop this cycle ? -1 : 0) < FQ_DEPTH.
  - On issue: req=1 for exactly one cycle, req_addr=fetch_pc.
  - The first request goes out on the first edge after reset release, so req=1 with addr RESET_PC in cycle 1.
  - WAIT to IDLE: on cache_valid.
  - If drop=0: push {fetch_pc_of_request, icache_ins} and set fetch_pc += 4, wrapping mod 2^XLEN.
  - If drop=1: discard the response and clear drop.
  - A new request may issue on the cycle after cache_valid, so minimum issue spacing is 2 cycles. Response latency is 1 or more cycles and is unbounded.
- Redirect (i_pc_update=1):
  - Flush the queue: count=0, pointers=0. o_post_valid=0 on the next cycle.
  - Set fetch_pc=i_pc_next & ~3.
  - If in WAIT with no cache_valid that cycle: set drop=1.
  - If cache_valid arrives in the same cycle: discard it and do not push.
  - Redirect has priority over push, pop and issue in the same cycle.
  - The request to the target issues once the FSM reaches IDLE with drop=0.
  - Repeated redirects: the last one wins; drop remains a single bit because at most one request is ever outstanding.
- Queue:
  - Circular buffer with log2(FQ_DEPTH)-bit pointers that wrap naturally.
  - Pop when o_post_valid && i_post_ready.
  - Push and pop in the same cycle: count unchanged, including when count is full or 1.
  - Push never occurs when full, because space is reserved at issue (count + outstanding ≤ FQ_DEPTH).
  - Pop while empty cannot happen, since o_post_valid=0.
- Output:
  - o_post_valid = (count != 0).
  - o_ins and o_pc_next are read combinationally from the head entry.
  - Output must hold stable while o_post_valid=1 and i_post_ready=0, unless a redirect occurs.
- o_hit_cnt: increments on an accepted (non-dropped) response with hit=1; wraps at 2^32.
- Stray inputs: cache_valid while in IDLE is ignored. hit and icache_ins are don't-care when cache_valid=0.

Test Plan:
- Reset release, cache responds 1 cycle after each req, i_post_ready=1:
  - req_addr sequence is 0x30000000, 0x30000004, 0x30000008.
  - IDU sees the same PCs in order with the matching icache_ins.
- i_post_ready=0, FQ_DEPTH=4:
  - Exactly 4 requests are issued, then req stays 0 and o_fq_count=4.
  - Head stays pc 0x30000000.
  - Raise ready for 1 cycle: one pop, then exactly one new request at 0x30000010.
- Redirect to 0x80000003 while WAIT at 0x30000008, response 3 cycles later:
  - The response is discarded and the queue is empty.
  - The next req_addr is 0x80000000.
  - The first IDU entry after redirect has pc 0x80000000.
- Redirect asserted in the same cycle as cache_valid:
  - The response is not pushed and o_hit_cnt is unchanged.
  - The next request goes to the target.
- fetch_pc=0xFFFFFFFC, sequential fetch: the next req_addr is 0x00000000 (wrap).
- Reset asserted mid-WAIT with 3 queued entries:
  - The next cycle has o_post_valid=0 and o_fq_count=0.
  - After release, req is re-issued at 0x30000000.
  - A stale cache_valid arriving during IDLE is ignored.

Source files
------------

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch unit with a sequential prefetcher and an FQ_DEPTH-entry {pc, ins} queue.
// At most one I-cache request is outstanding, and queue space is reserved when it issues.
module ifu_prefetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h3000_0000,
   parameter int unsigned     FQ_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      rst_n_sync,
   input  logic                      i_pc_update,
   input  logic [XLEN-1:0]           i_pc_next,
   output logic                      o_post_valid,
   input  logic                      i_post_ready,
   output logic [XLEN-1:0]           o_ins,
   output logic [XLEN-1:0]           o_pc_next,
   output logic                      req,
   output logic [XLEN-1:0]           req_addr,
   input  logic                      hit,
   input  logic [XLEN-1:0]           icache_ins,
   input  logic                      cache_valid,
   output logic [$clog2(FQ_DEPTH):0] o_fq_count,
   output logic [31:0]               o_hit_cnt
);

   localparam int unsigned PtrW = $clog2(FQ_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic {StIdle, StWait} state_e;

   state_e            state_q;
   logic              req_q;
   logic [XLEN-1:0]   req_addr_q;
   logic [XLEN-1:0]   fetch_pc_q;
   logic              drop_q;
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [CntW-1:0]   count_q;
   logic [31:0]       hit_cnt_q;
   logic [XLEN-1:0]   pc_mem_q  [FQ_DEPTH];
   logic [XLEN-1:0]   ins_mem_q [FQ_DEPTH];

   logic              rsp_valid;
   logic              push;
   logic              pop;
   logic              idle_nxt;
   logic              issue;
   logic [CntW-1:0]   count_d;
   logic [XLEN-1:0]   fetch_pc_d;
   logic              unused_pc_lsb;

   assign unused_pc_lsb = ^i_pc_next[1:0];

   always_comb begin
      rsp_valid = (state_q == StWait) && cache_valid;
      push      = rsp_valid && !drop_q && !i_pc_update;
      pop       = (count_q != '0) && i_post_ready && !i_pc_update;

      count_d = count_q + CntW'(push) - CntW'(pop);
      if (i_pc_update) begin
         count_d = '0;
      end

      fetch_pc_d = fetch_pc_q;
      if (i_pc_update) begin
         fetch_pc_d = {i_pc_next[XLEN-1:2], 2'b00};
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end

      // A response frees the port this cycle, so the next request can chain right behind it.
      idle_nxt = (state_q == StIdle) || rsp_valid;
      issue    = idle_nxt && !i_pc_update && (count_d < CntW'(FQ_DEPTH));
   end

   always_ff @(posedge clock) begin
      if (!rst_n_sync) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         req_addr_q <= '0;
         fetch_pc_q <= RESET_PC;
         drop_q     <= 1'b0;
      end else begin
         req_q      <= issue;
         fetch_pc_q <= fetch_pc_d;
         if (issue) begin
            req_addr_q <= fetch_pc_d;
         end
         if (i_pc_update) begin
            drop_q <= (state_q == StWait) && !cache_valid;
         end else if (rsp_valid) begin
            drop_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (issue) begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (rsp_valid && !issue) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n_sync || i_pc_update) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wptr_q <= wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem_q[wptr_q]  <= fetch_pc_q;
         ins_mem_q[wptr_q] <= icache_ins;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n_sync) begin
         hit_cnt_q <= '0;
      end else if (push && hit) begin
         hit_cnt_q <= hit_cnt_q + 32'd1;
      end
   end

   assign o_post_valid = (count_q != '0);
   assign o_ins        = ins_mem_q[rptr_q];
   assign o_pc_next    = pc_mem_q[rptr_q];
   assign req          = req_q;
   assign req_addr     = req_addr_q;
   assign o_fq_count   = count_q;
   assign o_hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed bench for ifu_prefetch_queue: sequential fetch, backpressure, redirects, wrap, reset.
module tb_ifu_prefetch_queue;

   logic        clock;
   logic        rst_n_sync;
   logic        i_pc_update;
   logic [31:0] i_pc_next;
   logic        o_post_valid;
   logic        i_post_ready;
   logic [31:0] o_ins;
   logic [31:0] o_pc_next;
   logic        req;
   logic [31:0] req_addr;
   logic        hit;
   logic [31:0] icache_ins;
   logic        cache_valid;
   logic [2:0]  o_fq_count;
   logic [31:0] o_hit_cnt;

   int checks = 0;
   int errors = 0;

   ifu_prefetch_queue #(
      .XLEN     (32),
      .RESET_PC (32'h3000_0000),
      .FQ_DEPTH (4)
   ) dut (
      .clock        (clock),
      .rst_n_sync   (rst_n_sync),
      .i_pc_update  (i_pc_update),
      .i_pc_next    (i_pc_next),
      .o_post_valid (o_post_valid),
      .i_post_ready (i_post_ready),
      .o_ins        (o_ins),
      .o_pc_next    (o_pc_next),
      .req          (req),
      .req_addr     (req_addr),
      .hit          (hit),
      .icache_ins   (icache_ins),
      .cache_valid  (cache_valid),
      .o_fq_count   (o_fq_count),
      .o_hit_cnt    (o_hit_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hold reset two cycles, release; afterwards the first request is visible.
   task automatic do_reset();
      rst_n_sync   = 1'b0;
      i_pc_update  = 1'b0;
      i_pc_next    = '0;
      i_post_ready = 1'b0;
      hit          = 1'b0;
      icache_ins   = '0;
      cache_valid  = 1'b0;
      step();
      step();
      rst_n_sync = 1'b1;
      step();
   endtask

   task automatic wait_req();
      int n = 0;
      while (!req && n < 20) begin
         step();
         n++;
      end
      if (!req) begin
         checks++;
         errors++;
         $display("FAIL wait_req: req=%0b after %0d cycles, required 1", req, n);
      end
   endtask

   // Answer the outstanding request one cycle after it was seen.
   task automatic respond(input logic [31:0] ins, input logic h);
      step();
      cache_valid = 1'b1;
      icache_ins  = ins;
      hit         = h;
      step();
      cache_valid = 1'b0;
      hit         = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_sync  = 1'b0;
      cache_valid = 1'b0;
      i_pc_update = 1'b0;
      step();
      checks++;
      if ({req, o_post_valid} !== 2'b00 || req_addr !== 32'h0 || o_fq_count !== 3'd0
          || o_hit_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: req=%0b valid=%0b addr=%h cnt=%0d hits=%0d, required all 0",
                  req, o_post_valid, req_addr, o_fq_count, o_hit_cnt);
      end
      do_reset();
      checks++;
      if (req !== 1'b1 || req_addr !== 32'h3000_0000) begin
         errors++;
         $display("FAIL first_req: req=%0b addr=%h, required 1 30000000", req, req_addr);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] ins;
      do_reset();
      i_post_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ins = 32'hA000_0000 + 32'(k);
         wait_req();
         checks++;
         if (req_addr !== 32'h3000_0000 + 32'(4 * k)) begin
            errors++;
            $display("FAIL seq_addr%0d: got %h, required %h", k, req_addr, 32'h3000_0000 + 32'(4 * k));
         end
         respond(ins, 1'b1);
         checks++;
         if (o_post_valid !== 1'b1 || o_pc_next !== 32'h3000_0000 + 32'(4 * k) || o_ins !== ins) begin
            errors++;
            $display("FAIL seq_head%0d: valid=%0b pc=%h ins=%h, required 1 %h %h", k, o_post_valid,
                     o_pc_next, o_ins, 32'h3000_0000 + 32'(4 * k), ins);
         end
      end
      checks++;
      if (o_hit_cnt !== 32'd3) begin
         errors++;
         $display("FAIL seq_hits: got %0d, required 3", o_hit_cnt);
      end
   endtask

   task automatic test_backpressure();
      int nreq = 0;
      do_reset();
      i_post_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_req();
         checks++;
         if (req_addr !== 32'h3000_0000 + 32'(4 * k)) begin
            errors++;
            $display("FAIL bp_addr%0d: got %h, required %h", k, req_addr, 32'h3000_0000 + 32'(4 * k));
         end
         respond(32'hB000_0000 + 32'(k), 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         if (req) nreq++;
         step();
      end
      checks++;
      if (nreq != 0 || o_fq_count !== 3'd4) begin
         errors++;
         $display("FAIL bp_full: extra_reqs=%0d cnt=%0d, required 0 4", nreq, o_fq_count);
      end
      checks++;
      if (o_pc_next !== 32'h3000_0000 || o_ins !== 32'hB000_0000 || o_hit_cnt !== 32'd0) begin
         errors++;
         $display("FAIL bp_head: pc=%h ins=%h hits=%0d, required 30000000 b0000000 0",
                  o_pc_next, o_ins, o_hit_cnt);
      end
      i_post_ready = 1'b1;
      step();
      i_post_ready = 1'b0;
      checks++;
      if (req !== 1'b1 || req_addr !== 32'h3000_0010 || o_fq_count !== 3'd3
          || o_pc_next !== 32'h3000_0004) begin
         errors++;
         $display("FAIL bp_pop: req=%0b addr=%h cnt=%0d pc=%h, required 1 30000010 3 30000004",
                  req, req_addr, o_fq_count, o_pc_next);
      end
      nreq = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (req) nreq++;
      end
      checks++;
      if (nreq != 0) begin
         errors++;
         $display("FAIL bp_single: extra_reqs=%0d, required 0", nreq);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      i_post_ready = 1'b0;
      respond(32'hC000_0000, 1'b0);
      respond(32'hC000_0001, 1'b0);
      step();
      i_pc_update = 1'b1;
      i_pc_next   = 32'h8000_0003;
      step();
      i_pc_update = 1'b0;
      checks++;
      if (o_post_valid !== 1'b0 || o_fq_count !== 3'd0) begin
         errors++;
         $display("FAIL redir_flush: valid=%0b cnt=%0d, required 0 0", o_post_valid, o_fq_count);
      end
      step();
      step();
      cache_valid = 1'b1;
      icache_ins  = 32'hDEAD_BEEF;
      hit         = 1'b1;
      step();
      cache_valid = 1'b0;
      hit         = 1'b0;
      checks++;
      if (o_fq_count !== 3'd0 || o_hit_cnt !== 32'd0 || req !== 1'b1 || req_addr !== 32'h8000_0000)
      begin
         errors++;
         $display("FAIL redir_drop: cnt=%0d hits=%0d req=%0b addr=%h, required 0 0 1 80000000",
                  o_fq_count, o_hit_cnt, req, req_addr);
      end
      respond(32'hC000_0080, 1'b1);
      checks++;
      if (o_post_valid !== 1'b1 || o_pc_next !== 32'h8000_0000 || o_ins !== 32'hC000_0080
          || o_hit_cnt !== 32'd1) begin
         errors++;
         $display("FAIL redir_head: valid=%0b pc=%h ins=%h hits=%0d, required 1 80000000 c0000080 1",
                  o_post_valid, o_pc_next, o_ins, o_hit_cnt);
      end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      i_post_ready = 1'b0;
      step();
      cache_valid = 1'b1;
      icache_ins  = 32'h1111_2222;
      hit         = 1'b1;
      i_pc_update = 1'b1;
      i_pc_next   = 32'h4000_0010;
      step();
      cache_valid = 1'b0;
      hit         = 1'b0;
      i_pc_update = 1'b0;
      checks++;
      if (o_fq_count !== 3'd0 || o_hit_cnt !== 32'd0 || req !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_drop: cnt=%0d hits=%0d req=%0b, required 0 0 0",
                  o_fq_count, o_hit_cnt, req);
      end
      step();
      checks++;
      if (req !== 1'b1 || req_addr !== 32'h4000_0010) begin
         errors++;
         $display("FAIL same_cycle_req: req=%0b addr=%h, required 1 40000010", req, req_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      i_post_ready = 1'b0;
      step();
      cache_valid = 1'b1;
      i_pc_update = 1'b1;
      i_pc_next   = 32'hFFFF_FFFF;
      step();
      cache_valid = 1'b0;
      i_pc_update = 1'b0;
      step();
      checks++;
      if (req !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_first: req=%0b addr=%h, required 1 fffffffc", req, req_addr);
      end
      respond(32'h5555_AAAA, 1'b0);
      checks++;
      if (req !== 1'b1 || req_addr !== 32'h0000_0000 || o_pc_next !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_next: req=%0b addr=%h head=%h, required 1 00000000 fffffffc",
                  req, req_addr, o_pc_next);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      i_post_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         respond(32'hE000_0000 + 32'(k), 1'b1);
      end
      step();
      rst_n_sync = 1'b0;
      step();
      checks++;
      if (o_post_valid !== 1'b0 || o_fq_count !== 3'd0 || req !== 1'b0 || o_hit_cnt !== 32'd0) begin
         errors++;
         $display("FAIL midwait_reset: valid=%0b cnt=%0d req=%0b hits=%0d, required 0 0 0 0",
                  o_post_valid, o_fq_count, req, o_hit_cnt);
      end
      rst_n_sync  = 1'b1;
      cache_valid = 1'b1;
      icache_ins  = 32'hBAD0_BAD0;
      hit         = 1'b1;
      step();
      cache_valid = 1'b0;
      hit         = 1'b0;
      checks++;
      if (req !== 1'b1 || req_addr !== 32'h3000_0000 || o_fq_count !== 3'd0 || o_hit_cnt !== 32'd0)
      begin
         errors++;
         $display("FAIL stale_ignored: req=%0b addr=%h cnt=%0d hits=%0d, required 1 30000000 0 0",
                  req, req_addr, o_fq_count, o_hit_cnt);
      end
      respond(32'hF000_0001, 1'b1);
      checks++;
      if (o_pc_next !== 32'h3000_0000 || o_ins !== 32'hF000_0001 || o_fq_count !== 3'd1) begin
         errors++;
         $display("FAIL midwait_refetch: pc=%h ins=%h cnt=%0d, required 30000000 f0000001 1",
                  o_pc_next, o_ins, o_fq_count);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_wrap();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
